// File: rtl/ser_param_if.sv
// Word handshake between the word generator (master) and the serializer (slave).
// data_ready is driven by the serializer and reflects an empty holding buffer.
interface ser_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/ser_param.sv
// Parametrised parallel-to-serial converter with a one-word holding buffer,
// gap-free back-to-back framing, frame marker, underrun pulse and word counter.
module ser_param #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int COUNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    ser_param_if.slave         bus,
    output logic               data_out,
    output logic               frame_start,
    output logic               busy,
    output logic               underrun,
    output logic [COUNT_W-1:0] word_count
);

    localparam int                BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t               r_state;
    logic [DATA_W-1:0]    r_hold;
    logic                 r_hold_full;
    logic [DATA_W-1:0]    r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_data_out;
    logic                 r_frame_start;
    logic                 r_busy;
    logic                 r_underrun;
    logic [COUNT_W-1:0]   r_word_count;

    logic                 w_accept;
    logic                 w_first_bit;
    logic                 w_next_bit;
    logic [DATA_W-1:0]    w_shift_next;
    logic                 w_last;

    // Accept only into an empty buffer; the drain edge can never coincide with an accept.
    assign w_accept     = bus.data_valid && !r_hold_full;
    assign w_first_bit  = MSB_FIRST ? r_hold[DATA_W-1] : r_hold[0];
    assign w_next_bit   = MSB_FIRST ? r_shift[DATA_W-2] : r_shift[1];
    assign w_shift_next = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
    assign w_last       = (r_bit_cnt == LAST_BIT);

    assign bus.data_ready = !r_hold_full;
    assign data_out       = r_data_out;
    assign frame_start    = r_frame_start;
    assign busy           = r_busy;
    assign underrun       = r_underrun;
    assign word_count     = r_word_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_data_out    <= IDLE_BIT;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_underrun    <= 1'b0;
            r_word_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below reads
            // pre-edge values (e.g. r_hold is drained before a new accept lands).
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;

            if (w_accept) begin
                r_hold      <= bus.data_in;
                r_hold_full <= 1'b1;
            end

            if (enable) begin
                case (r_state)
                    S_IDLE: begin
                        r_data_out <= IDLE_BIT;
                        if (r_hold_full) begin
                            r_shift       <= r_hold;
                            r_hold_full   <= 1'b0;
                            r_bit_cnt     <= '0;
                            r_state       <= S_SHIFT;
                            r_busy        <= 1'b1;
                            r_data_out    <= w_first_bit;
                            r_frame_start <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (w_last) begin
                            r_word_count <= r_word_count + COUNT_W'(1);
                            if (r_hold_full) begin
                                r_shift       <= r_hold;
                                r_hold_full   <= 1'b0;
                                r_bit_cnt     <= '0;
                                r_data_out    <= w_first_bit;
                                r_frame_start <= 1'b1;
                            end else begin
                                r_state    <= S_IDLE;
                                r_busy     <= 1'b0;
                                r_data_out <= IDLE_BIT;
                                r_underrun <= 1'b1;
                            end
                        end else begin
                            r_shift    <= w_shift_next;
                            r_data_out <= w_next_bit;
                            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser_param.sv
// Bench for ser_param: directed scenarios plus a randomized run, all checked against
// a word/bit-queue model of the serializer; two extra instances cover LSB-first and wrap.
module tb_ser_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    ser_param_if #(.DATA_W(8)) bus0 ();
    ser_param_if #(.DATA_W(8)) bus1 ();
    ser_param_if #(.DATA_W(8)) bus2 ();

    assign bus1.data_in    = bus0.data_in;
    assign bus1.data_valid = bus0.data_valid;
    assign bus2.data_in    = bus0.data_in;
    assign bus2.data_valid = bus0.data_valid;

    logic        out0, fs0, busy0, und0;
    logic [15:0] cnt0;
    logic        out1, fs1, busy1, und1;
    logic [15:0] cnt1;
    logic        out2, fs2, busy2, und2;
    logic [1:0]  cnt2;

    ser_param #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .COUNT_W(16)) u0 (
        .clock(clk), .reset(rst), .enable(en), .bus(bus0),
        .data_out(out0), .frame_start(fs0), .busy(busy0), .underrun(und0), .word_count(cnt0));

    ser_param #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .COUNT_W(16)) u1 (
        .clock(clk), .reset(rst), .enable(en), .bus(bus1),
        .data_out(out1), .frame_start(fs1), .busy(busy1), .underrun(und1), .word_count(cnt1));

    ser_param #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .COUNT_W(2)) u2 (
        .clock(clk), .reset(rst), .enable(en), .bus(bus2),
        .data_out(out2), .frame_start(fs2), .busy(busy2), .underrun(und2), .word_count(cnt2));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model of u0: pending words and the not-yet-shown bits of the current word.
    logic [7:0]  m_pend[$];
    bit          m_cur[$];
    logic        m_out, m_fs, m_busy, m_und;
    logic [15:0] m_cnt;

    logic [31:0] rec_bits0, rec_fs0, rec_bits1;
    int          rec_n0, rec_fs_n0, rec_und0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_cur.delete();
        m_out  = 1'b0;
        m_fs   = 1'b0;
        m_busy = 1'b0;
        m_und  = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic rec_reset();
        rec_bits0 = '0; rec_fs0 = '0; rec_bits1 = '0;
        rec_n0 = 0; rec_fs_n0 = 0; rec_und0 = 0;
    endtask

    task automatic model_load();
        logic [7:0] w;
        w = m_pend.pop_front();
        for (int i = 7; i >= 0; i--) m_cur.push_back(w[i]);
        m_out  = m_cur.pop_front();
        m_fs   = 1'b1;
        m_busy = 1'b1;
    endtask

    task automatic model_step();
        bit acc;
        acc  = bus0.data_valid && (m_pend.size() == 0);
        m_fs  = 1'b0;
        m_und = 1'b0;
        if (en) begin
            if (m_busy && m_cur.size() > 0) begin
                m_out = m_cur.pop_front();
            end else begin
                if (m_busy) m_cnt = m_cnt + 16'd1;
                if (m_pend.size() > 0) begin
                    model_load();
                end else begin
                    if (m_busy) m_und = 1'b1;
                    m_busy = 1'b0;
                    m_out  = 1'b0;
                end
            end
        end
        if (acc) m_pend.push_back(bus0.data_in);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check($sformatf("c%0d data_out", cyc), out0, m_out);
        check($sformatf("c%0d frame_start", cyc), fs0, m_fs);
        check($sformatf("c%0d busy", cyc), busy0, m_busy);
        check($sformatf("c%0d underrun", cyc), und0, m_und);
        check($sformatf("c%0d word_count", cyc), cnt0, m_cnt);
        check($sformatf("c%0d data_ready", cyc), bus0.data_ready, (m_pend.size() == 0));
        if (busy0) begin
            rec_bits0 = {rec_bits0[30:0], out0};
            rec_fs0   = {rec_fs0[30:0], fs0};
            rec_n0++;
            if (fs0) rec_fs_n0++;
        end
        if (busy1) rec_bits1 = {rec_bits1[30:0], out1};
        if (und0) rec_und0++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [7:0] w);
        bit r;
        bit accepted;
        accepted = 1'b0;
        bus0.data_in    = w;
        bus0.data_valid = 1'b1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            r = bus0.data_ready;
            cycle();
            if (r) accepted = 1'b1;
        end
        check($sformatf("send %0h accepted", w), accepted, 1'b1);
        bus0.data_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus0.data_in    = '0;
        bus0.data_valid = 1'b0;
        model_reset();
        rec_reset();

        // Reset state
        #3;
        check("rst data_out", out0, 1'b0);
        check("rst frame_start", fs0, 1'b0);
        check("rst busy", busy0, 1'b0);
        check("rst underrun", und0, 1'b0);
        check("rst word_count", cnt0, 16'd0);
        check("rst data_ready", bus0.data_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1+2: single word, MSB-first on u0 and LSB-first on u1
        en = 1'b1;
        rec_reset();
        send(8'b10111011);
        check("t1 latency busy", busy0, 1'b0);
        cycle();
        check("t1 first bit", out0, 1'b1);
        check("t1 first fs", fs0, 1'b1);
        run(10);
        check("t1 bits", rec_bits0[7:0], 8'hBB);
        check("t1 fs mask", rec_fs0[7:0], 8'h80);
        check("t1 bit count", rec_n0, 8);
        check("t1 underruns", rec_und0, 1);
        check("t1 word_count", cnt0, 16'd1);
        check("t2 lsb bits", rec_bits1[7:0], 8'b11011101);
        check("t2 word_count", cnt1, 16'd1);

        // 3: back-to-back words with no gap
        do_reset();
        rec_reset();
        send(8'hBB);
        send(8'h0F);
        run(20);
        check("t3 bits", rec_bits0[15:0], 16'hBB0F);
        check("t3 fs mask", rec_fs0[15:0], 16'h8080);
        check("t3 bit count", rec_n0, 16);
        check("t3 underruns", rec_und0, 1);
        check("t3 word_count", cnt0, 16'd2);

        // 4: enable low for 3 cycles while bit 3 is shown
        rec_reset();
        send(8'hBB);
        for (int i = 0; i < 20 && m_cur.size() != 4; i++) cycle();
        check("t4 reached bit3", m_cur.size(), 4);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4 hold data_out", out0, 1'b1);
            check("t4 hold busy", busy0, 1'b1);
        end
        en = 1'b1;
        run(10);
        check("t4 busy cycles", rec_n0, 11);
        check("t4 fs count", rec_fs_n0, 1);

        // 5: asynchronous reset at bit 5 with a second word held
        do_reset();
        rec_reset();
        send(8'hC3);
        send(8'h99);
        for (int i = 0; i < 20 && m_cur.size() != 2; i++) cycle();
        check("t5 reached bit5", m_cur.size(), 2);
        #2;
        rst = 1'b1;
        #1;
        check("t5 async data_out", out0, 1'b0);
        check("t5 async frame_start", fs0, 1'b0);
        check("t5 async busy", busy0, 1'b0);
        check("t5 async underrun", und0, 1'b0);
        check("t5 async word_count", cnt0, 16'd0);
        check("t5 async data_ready", bus0.data_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rec_reset();
        run(12);
        check("t5 no bits after reset", rec_n0, 0);
        check("t5 word_count", cnt0, 16'd0);
        check("t5 data_ready", bus0.data_ready, 1'b1);

        // 6: backpressure while hold is full, then counter wrap on the 2-bit instance
        rec_reset();
        send(8'hA5);
        send(8'h5A);
        bus0.data_in    = 8'h11;
        bus0.data_valid = 1'b1;
        cycle();
        check("t6 ready low a", bus0.data_ready, 1'b0);
        bus0.data_in = 8'h22;
        cycle();
        check("t6 ready low b", bus0.data_ready, 1'b0);
        bus0.data_valid = 1'b0;
        run(20);
        check("t6 bits unchanged", rec_bits0[15:0], 16'hA55A);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        run(30);
        check("t6 word_count", cnt0, 16'd5);
        check("t6 wrap count", cnt2, 2'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            en              = ($urandom_range(0, 3) != 0);
            bus0.data_valid = $urandom_range(0, 1);
            bus0.data_in    = 8'($urandom);
            cycle();
        end
        en              = 1'b1;
        bus0.data_valid = 1'b0;
        run(24);
        check("rand drained", busy0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
